// File: rtl/dalu_seq.sv
// Sequential ALU: single-cycle add/sub/compare, iterative shift-add multiply
// and restoring divide, driven through a start/busy/done handshake.
module dalu_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cf,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] acc,
    output logic [W-1:0] c,
    output logic         c_flag,
    output logic         z_flag,
    output logic         o_flag,
    output logic         n_flag,
    output logic         dz_flag
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_ADC  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_SUC  = 8'h04;
    localparam logic [7:0] OP_MUL  = 8'h05;
    localparam logic [7:0] OP_DIV  = 8'h06;
    localparam logic [7:0] OP_CMP  = 8'h07;
    localparam logic [7:0] OP_CMPS = 8'h08;

    localparam logic [5:0] LAST_ITER = 6'(W - 1);

    logic [1:0]   state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] opnd_q, opnd_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] c_q, c_d;
    logic         cflag_q, cflag_d;
    logic         zflag_q, zflag_d;
    logic         oflag_q, oflag_d;
    logic         nflag_q, nflag_d;
    logic         dzflag_q, dzflag_d;
    logic         done_q, done_d;

    logic [W:0]   sum;
    logic [W:0]   diff;
    logic         carry_in;
    logic [W:0]   mul_sum;
    logic [W-1:0] mul_hi;
    logic [W-1:0] mul_lo;
    logic [W:0]   div_sh;
    logic [W:0]   div_trial;
    logic [W-1:0] div_rem;
    logic [W-1:0] div_lo;

    // Datapath for one add/sub and one multiply/divide iteration. The
    // iterative ops keep their working values in hi/lo so acc and c hold
    // their old contents until the completion edge.
    always_comb begin
        carry_in  = cf && (op == OP_ADC || op == OP_SUC);
        sum       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
        diff      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, carry_in};
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        mul_hi    = mul_sum[W:1];
        mul_lo    = {mul_sum[0], lo_q[W-1:1]};
        div_sh    = {hi_q, lo_q[W-1]};
        div_trial = div_sh - {1'b0, opnd_q};
        div_rem   = div_trial[W] ? div_sh[W-1:0] : div_trial[W-1:0];
        div_lo    = {lo_q[W-2:0], ~div_trial[W]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        c_d      = c_q;
        cflag_d  = cflag_q;
        zflag_d  = zflag_q;
        oflag_d  = oflag_q;
        nflag_d  = nflag_q;
        dzflag_d = dzflag_q;
        done_d   = 1'b0;

        if (state_q == S_IDLE) begin
            if (start) begin
                done_d = 1'b1;
                case (op)
                    OP_ADD, OP_ADC: begin
                        acc_d    = sum[W-1:0];
                        cflag_d  = sum[W];
                        oflag_d  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
                        nflag_d  = sum[W-1];
                        zflag_d  = (sum[W-1:0] == '0);
                        dzflag_d = 1'b0;
                    end
                    OP_SUB, OP_SUC: begin
                        acc_d    = diff[W-1:0];
                        cflag_d  = diff[W];
                        oflag_d  = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
                        nflag_d  = diff[W-1];
                        zflag_d  = (diff[W-1:0] == '0);
                        dzflag_d = 1'b0;
                    end
                    OP_MUL: begin
                        done_d  = 1'b0;
                        state_d = S_MUL;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = a;
                        opnd_d  = b;
                    end
                    OP_DIV: begin
                        if (b == '0) begin
                            acc_d    = '1;
                            c_d      = a;
                            dzflag_d = 1'b1;
                            zflag_d  = 1'b0;
                            cflag_d  = 1'b0;
                            oflag_d  = 1'b0;
                            nflag_d  = 1'b0;
                        end else begin
                            done_d  = 1'b0;
                            state_d = S_DIV;
                            cnt_d   = '0;
                            hi_d    = '0;
                            lo_d    = a;
                            opnd_d  = b;
                        end
                    end
                    OP_CMP: begin
                        zflag_d  = (a == b);
                        cflag_d  = (a < b);
                        oflag_d  = (a > b);
                        nflag_d  = 1'b0;
                        dzflag_d = 1'b0;
                    end
                    OP_CMPS: begin
                        zflag_d  = (a == b);
                        cflag_d  = ($signed(a) < $signed(b));
                        oflag_d  = ($signed(a) > $signed(b));
                        nflag_d  = 1'b0;
                        dzflag_d = 1'b0;
                    end
                    default: ;
                endcase
            end
        end else begin
            cnt_d = cnt_q + 6'd1;
            if (state_q == S_MUL) begin
                hi_d = mul_hi;
                lo_d = mul_lo;
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    c_d      = mul_hi;
                    acc_d    = mul_lo;
                    zflag_d  = ({mul_hi, mul_lo} == '0);
                    oflag_d  = (mul_hi != '0);
                    nflag_d  = mul_lo[W-1];
                    cflag_d  = 1'b0;
                    dzflag_d = 1'b0;
                end
            end else begin
                hi_d = div_rem;
                lo_d = div_lo;
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    acc_d    = div_lo;
                    c_d      = div_rem;
                    zflag_d  = (div_lo == '0);
                    oflag_d  = 1'b0;
                    nflag_d  = 1'b0;
                    cflag_d  = 1'b0;
                    dzflag_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            c_q      <= '0;
            cflag_q  <= 1'b0;
            zflag_q  <= 1'b0;
            oflag_q  <= 1'b0;
            nflag_q  <= 1'b0;
            dzflag_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
            cflag_q  <= cflag_d;
            zflag_q  <= zflag_d;
            oflag_q  <= oflag_d;
            nflag_q  <= nflag_d;
            dzflag_q <= dzflag_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign acc     = acc_q;
    assign c       = c_q;
    assign c_flag  = cflag_q;
    assign z_flag  = zflag_q;
    assign o_flag  = oflag_q;
    assign n_flag  = nflag_q;
    assign dz_flag = dzflag_q;

endmodule

// File: tb/tb_dalu_seq.sv
// Directed bench for dalu_seq at W=16: hand-computed vectors covering every
// opcode, handshake timing, mid-operation reset and back-to-back issue.
module tb_dalu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cf;
    logic         busy;
    logic         done;
    logic [W-1:0] acc;
    logic [W-1:0] c;
    logic         c_flag;
    logic         z_flag;
    logic         o_flag;
    logic         n_flag;
    logic         dz_flag;

    int checks = 0;
    int errors = 0;
    int edges;
    int busy_cycles;
    int done_seen;

    logic [4:0] flags;
    assign flags = {c_flag, z_flag, o_flag, n_flag, dz_flag};

    dalu_seq #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cf      (cf),
        .busy    (busy),
        .done    (done),
        .acc     (acc),
        .c       (c),
        .c_flag  (c_flag),
        .z_flag  (z_flag),
        .o_flag  (o_flag),
        .n_flag  (n_flag),
        .dz_flag (dz_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] op_i, input logic [W-1:0] a_i,
                                 input logic [W-1:0] b_i, input logic cf_i);
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        b     = b_i;
        cf    = cf_i;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after accept until done is seen, and busy-high samples.
    task automatic waitDone();
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 8'h00; a = '0; b = '0; cf = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checkOutput("reset_acc",   32'(acc), 32'h0000);
        checkOutput("reset_c",     32'(c), 32'h0000);
        checkOutput("reset_flags", 32'(flags), 32'h00);
        checkOutput("reset_busy",  32'(busy), 32'h0);
        checkOutput("reset_done",  32'(done), 32'h0);

        // flags order: {c, z, o, n, dz}
        applyStimulus(8'h01, 16'h7FFF, 16'h0001, 1'b0);
        checkOutput("add1_done",  32'(done), 32'h1);
        checkOutput("add1_acc",   32'(acc), 32'h8000);
        checkOutput("add1_flags", 32'(flags), 32'b00110);
        tick();
        checkOutput("add1_done_pulse", 32'(done), 32'h0);

        applyStimulus(8'h01, 16'hFFFF, 16'h0001, 1'b0);
        checkOutput("add2_acc",   32'(acc), 32'h0000);
        checkOutput("add2_flags", 32'(flags), 32'b11000);

        applyStimulus(8'h02, 16'h0001, 16'h0002, 1'b1);
        checkOutput("adc_acc",   32'(acc), 32'h0004);
        checkOutput("adc_flags", 32'(flags), 32'b00000);

        applyStimulus(8'h04, 16'h0000, 16'h0000, 1'b1);
        checkOutput("suc_acc",   32'(acc), 32'hFFFF);
        checkOutput("suc_flags", 32'(flags), 32'b10010);

        applyStimulus(8'h03, 16'h8000, 16'h0001, 1'b1);
        checkOutput("sub_acc",   32'(acc), 32'h7FFF);
        checkOutput("sub_flags", 32'(flags), 32'b00100);
        checkOutput("sub_c",     32'(c), 32'h0000);

        // MUL with a stray start injected while busy
        applyStimulus(8'h05, 16'h1234, 16'h5678, 1'b0);
        checkOutput("mul_busy_rise", 32'(busy), 32'h1);
        start = 1'b1; op = 8'h01; a = 16'h0001; b = 16'h0001;
        tick();
        start = 1'b0;
        checkOutput("mul_acc_hold", 32'(acc), 32'h7FFF);
        checkOutput("mul_flags_hold", 32'(flags), 32'b00100);
        waitDone();
        checkOutput("mul_latency", 32'(edges + 1), 32'd16);
        checkOutput("mul_busy_cycles", 32'(busy_cycles + 1), 32'd16);
        checkOutput("mul_busy_fall", 32'(busy), 32'h0);
        checkOutput("mul_c",     32'(c), 32'h0626);
        checkOutput("mul_acc",   32'(acc), 32'h0060);
        checkOutput("mul_flags", 32'(flags), 32'b00100);
        tick();
        checkOutput("mul_done_pulse", 32'(done), 32'h0);

        applyStimulus(8'h06, 16'd1000, 16'd7, 1'b0);
        waitDone();
        checkOutput("div_latency", 32'(edges), 32'd16);
        checkOutput("div_acc",   32'(acc), 32'h008E);
        checkOutput("div_c",     32'(c), 32'h0006);
        checkOutput("div_flags", 32'(flags), 32'b00000);

        applyStimulus(8'h06, 16'd3, 16'd5, 1'b0);
        waitDone();
        checkOutput("div_small_acc",   32'(acc), 32'h0000);
        checkOutput("div_small_c",     32'(c), 32'h0003);
        checkOutput("div_small_flags", 32'(flags), 32'b01000);

        applyStimulus(8'h06, 16'h1234, 16'h0000, 1'b0);
        checkOutput("div0_done",  32'(done), 32'h1);
        checkOutput("div0_busy",  32'(busy), 32'h0);
        checkOutput("div0_acc",   32'(acc), 32'hFFFF);
        checkOutput("div0_c",     32'(c), 32'h1234);
        checkOutput("div0_flags", 32'(flags), 32'b00001);

        applyStimulus(8'h07, 16'hFFFF, 16'h0001, 1'b0);
        checkOutput("cmp_flags", 32'(flags), 32'b00100);
        applyStimulus(8'h08, 16'hFFFF, 16'h0001, 1'b0);
        checkOutput("cmps_flags", 32'(flags), 32'b10000);
        applyStimulus(8'h07, 16'h5555, 16'h5555, 1'b0);
        checkOutput("cmp_eq_flags", 32'(flags), 32'b01000);
        checkOutput("cmp_acc_hold", 32'(acc), 32'hFFFF);
        checkOutput("cmp_c_hold",   32'(c), 32'h1234);

        applyStimulus(8'h09, 16'h0001, 16'h0001, 1'b1);
        checkOutput("unk_done",  32'(done), 32'h1);
        checkOutput("unk_acc",   32'(acc), 32'hFFFF);
        checkOutput("unk_flags", 32'(flags), 32'b01000);

        // Reset during the fifth MUL iteration
        applyStimulus(8'h05, 16'h1234, 16'h5678, 1'b0);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_busy",  32'(busy), 32'h0);
        checkOutput("rst_mid_done",  32'(done), 32'h0);
        checkOutput("rst_mid_acc",   32'(acc), 32'h0000);
        checkOutput("rst_mid_c",     32'(c), 32'h0000);
        checkOutput("rst_mid_flags", 32'(flags), 32'b00000);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) done_seen++;
            tick();
        end
        checkOutput("rst_mid_no_done", 32'(done_seen), 32'd0);

        // Back-to-back: ADD presented while MUL done is high
        applyStimulus(8'h05, 16'h00FF, 16'h0100, 1'b0);
        waitDone();
        checkOutput("b2b_mul_c",     32'(c), 32'h0000);
        checkOutput("b2b_mul_acc",   32'(acc), 32'hFF00);
        checkOutput("b2b_mul_flags", 32'(flags), 32'b00010);
        applyStimulus(8'h01, 16'h0003, 16'h0004, 1'b0);
        checkOutput("b2b_add_done",  32'(done), 32'h1);
        checkOutput("b2b_add_acc",   32'(acc), 32'h0007);
        checkOutput("b2b_add_flags", 32'(flags), 32'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
